// File: rtl/ase_pkg.sv
// Shared UMsg definitions: slot state encoding, slot status view, RX0 UMsg
// header layout, command bundle and the default dispatch delays.
package ase_pkg;

    localparam int NUM_UMSG_PER_AFU      = 8;
    localparam int UMSG_DELAY_TIMER_LOG2 = 8;
    localparam int UMSG_HINT_DELAY       = 16;
    localparam int UMSG_DATA_DELAY       = 32;
    localparam int CCIP_DATA_WIDTH       = 512;
    localparam int UMSG_ID_W             = 6;

    localparam logic [3:0] CCIP_RX0_UMSG = 4'hF;

    typedef enum logic [1:0] {
        UMsg_Idle     = 2'd0,
        UMsg_SendHint = 2'd1,
        UMsg_Waiting  = 2'd2,
        UMsg_SendData = 2'd3
    } UMsg_StateEnum;

    // Per-slot status as seen by the dispatcher
    typedef struct packed {
        UMsg_StateEnum state;
        logic          hint_ready;
        logic          data_ready;
        logic          line_accessed;
    } umsg_t;

    // 28-bit RX0 UMsg header
    typedef struct packed {
        logic [3:0]           resp_type;
        logic                 umsg_type;
        logic                 poison;
        logic [15:0]          rsvd;
        logic [UMSG_ID_W-1:0] umsg_id;
    } UMsgHdr_t;

    typedef struct packed {
        logic [UMSG_ID_W-1:0]       id;
        logic [CCIP_DATA_WIDTH-1:0] data;
    } umsgcmd_t;

    // Build an RX0 UMsg header for a hint (is_hint=1) or a data message
    function automatic UMsgHdr_t umsg_hdr(input logic is_hint, input logic [UMSG_ID_W-1:0] id);
        UMsgHdr_t h;
        h           = '0;
        h.resp_type = CCIP_RX0_UMSG;
        h.umsg_type = is_hint;
        h.umsg_id   = id;
        return h;
    endfunction

endpackage

// File: rtl/ase_umsg_slot.sv
// One UMsg slot: hint/data state machine, hint and data delay timers and the
// latest payload written to this slot.
module ase_umsg_slot
    import ase_pkg::*;
#(
    parameter int TIMER_W    = UMSG_DELAY_TIMER_LOG2,
    parameter int HINT_DELAY = UMSG_HINT_DELAY,
    parameter int DATA_DELAY = UMSG_DATA_DELAY,
    parameter int DATA_W     = CCIP_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              hint_en,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              hint_done,
    input  logic              data_done,
    output umsg_t             status,
    output logic [DATA_W-1:0] data
);

    localparam logic [TIMER_W-1:0] HINT_LOAD = TIMER_W'(HINT_DELAY);
    localparam logic [TIMER_W-1:0] DATA_LOAD = TIMER_W'(DATA_DELAY);

    UMsg_StateEnum      state_reg, state_next;
    logic [TIMER_W-1:0] hint_timer_reg, hint_timer_next;
    logic [TIMER_W-1:0] data_timer_reg, data_timer_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               line_accessed_reg, line_accessed_next;

    // State, timer and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= UMsg_Idle;
            hint_timer_reg    <= '0;
            data_timer_reg    <= '0;
            data_reg          <= '0;
            line_accessed_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            hint_timer_reg    <= hint_timer_next;
            data_timer_reg    <= data_timer_next;
            data_reg          <= data_next;
            line_accessed_reg <= line_accessed_next;
        end
    end

    // Next-state: timers count down and saturate at 0; a command arriving
    // while a message is already pending only refreshes the payload
    always_comb begin
        state_next         = state_reg;
        hint_timer_next    = hint_timer_reg;
        data_timer_next    = data_timer_reg;
        data_next          = data_reg;
        line_accessed_next = line_accessed_reg;
        case (state_reg)
            UMsg_Idle: begin
                if (accept) begin
                    data_next          = cmd_data;
                    line_accessed_next = 1'b0;
                    if (hint_en) begin
                        state_next      = UMsg_SendHint;
                        hint_timer_next = HINT_LOAD;
                    end else begin
                        state_next      = UMsg_Waiting;
                        data_timer_next = DATA_LOAD;
                    end
                end
            end
            UMsg_SendHint: begin
                if (hint_timer_reg != '0)
                    hint_timer_next = hint_timer_reg - 1'b1;
                if (hint_done) begin
                    state_next      = UMsg_Waiting;
                    data_timer_next = DATA_LOAD;
                end
                if (accept) begin
                    data_next          = cmd_data;
                    line_accessed_next = 1'b1;
                end
            end
            UMsg_Waiting: begin
                // Moving on the edge where the timer reaches 0 makes data
                // eligible exactly DATA_DELAY cycles after the load
                if (data_timer_reg <= TIMER_W'(1)) begin
                    state_next      = UMsg_SendData;
                    data_timer_next = '0;
                end else begin
                    data_timer_next = data_timer_reg - 1'b1;
                end
                if (accept) begin
                    data_next          = cmd_data;
                    line_accessed_next = 1'b1;
                end
            end
            UMsg_SendData: begin
                if (data_done) begin
                    state_next         = UMsg_Idle;
                    line_accessed_next = 1'b0;
                end
            end
            default: state_next = UMsg_Idle;
        endcase
    end

    // Status outputs toward the dispatcher
    always_comb begin
        status.state         = state_reg;
        status.hint_ready    = (state_reg == UMsg_SendHint) && (hint_timer_reg == '0);
        status.data_ready    = (state_reg == UMsg_SendData);
        status.line_accessed = line_accessed_reg;
        data                 = data_reg;
    end

endmodule

// File: rtl/ase_umsg_dispatch.sv
// UMsg dispatcher: routes commands to per-slot state machines and serialises
// ready hints/data onto one registered RX0 valid/ready port. Hints win over
// data; each class has its own round-robin pointer.
module ase_umsg_dispatch
    import ase_pkg::*;
#(
    parameter int NUM_UMSG   = NUM_UMSG_PER_AFU,
    parameter int TIMER_W    = UMSG_DELAY_TIMER_LOG2,
    parameter int HINT_DELAY = UMSG_HINT_DELAY,
    parameter int DATA_DELAY = UMSG_DATA_DELAY
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       umsg_cmd_valid,
    input  logic [UMSG_ID_W-1:0]       umsg_cmd_id,
    input  logic [CCIP_DATA_WIDTH-1:0] umsg_cmd_data,
    output logic                       umsg_cmd_ready,
    input  logic [NUM_UMSG-1:0]        umsg_hint_en,
    output logic                       umsg_out_valid,
    output logic [27:0]                umsg_out_hdr,
    output logic [CCIP_DATA_WIDTH-1:0] umsg_out_data,
    input  logic                       umsg_out_ready,
    output logic                       umsg_err
);

    localparam int IDX_W  = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;
    localparam int DATA_W = CCIP_DATA_WIDTH;

    umsgcmd_t            cmd;
    logic                cmd_fire;
    logic                id_out_of_range;
    logic                busy_sel;

    umsg_t               status    [NUM_UMSG];
    logic [DATA_W-1:0]   slot_data [NUM_UMSG];
    logic [NUM_UMSG-1:0] slot_accept, slot_busy, hint_done, data_done, hint_req, data_req;

    logic                out_valid_reg;
    UMsgHdr_t            hdr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                out_fire;
    logic                load_en;
    logic                err_reg;

    logic [IDX_W-1:0]    hint_ptr_reg, data_ptr_reg;
    logic [IDX_W:0]      hint_pick, data_pick;

    // First requester at or after ptr, cyclically; returns {found, index}
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_UMSG-1:0] req,
                                               input logic [IDX_W-1:0]    ptr);
        logic [IDX_W:0] pick;
        int             idx;
        pick = '0;
        for (int k = NUM_UMSG - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_UMSG;
            if (req[idx])
                pick = {1'b1, IDX_W'(idx)};
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return IDX_W'((int'(idx) + 1) % NUM_UMSG);
    endfunction

    assign cmd.id          = umsg_cmd_id;
    assign cmd.data        = umsg_cmd_data;
    assign id_out_of_range = ({1'b0, cmd.id} >= 7'(NUM_UMSG));
    assign cmd_fire        = umsg_cmd_valid && umsg_cmd_ready;
    assign out_fire        = out_valid_reg && umsg_out_ready;
    assign load_en         = !out_valid_reg || umsg_out_ready;

    // Back-pressure only the slot whose data message is on its way out
    always_comb begin
        busy_sel = 1'b0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            if (cmd.id == UMSG_ID_W'(i))
                busy_sel = slot_busy[i];
        end
    end

    assign umsg_cmd_ready = !busy_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UMSG; gi++) begin : g_slot
            logic in_out_reg;

            // A slot whose message already sits in the output register must
            // not be granted again until that message has left
            assign in_out_reg      = out_valid_reg && (hdr_reg.umsg_id == UMSG_ID_W'(gi));
            assign slot_accept[gi] = cmd_fire && (cmd.id == UMSG_ID_W'(gi));
            assign hint_done[gi]   = out_fire && in_out_reg && hdr_reg.umsg_type;
            assign data_done[gi]   = out_fire && in_out_reg && !hdr_reg.umsg_type;
            assign slot_busy[gi]   = (status[gi].state == UMsg_SendData);
            assign hint_req[gi]    = status[gi].hint_ready && !in_out_reg;
            assign data_req[gi]    = status[gi].data_ready && !in_out_reg;

            ase_umsg_slot #(
                .TIMER_W    (TIMER_W),
                .HINT_DELAY (HINT_DELAY),
                .DATA_DELAY (DATA_DELAY),
                .DATA_W     (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .accept    (slot_accept[gi]),
                .hint_en   (umsg_hint_en[gi]),
                .cmd_data  (cmd.data),
                .hint_done (hint_done[gi]),
                .data_done (data_done[gi]),
                .status    (status[gi]),
                .data      (slot_data[gi])
            );
        end
    endgenerate

    // Round-robin selection within the hint class and within the data class
    always_comb begin
        hint_pick = rr_pick(hint_req, hint_ptr_reg);
        data_pick = rr_pick(data_req, data_ptr_reg);
    end

    // Output register: refills when empty or on a handshake, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            hdr_reg       <= '0;
            data_reg      <= '0;
        end else if (load_en) begin
            if (hint_pick[IDX_W]) begin
                out_valid_reg <= 1'b1;
                hdr_reg       <= umsg_hdr(1'b1, UMSG_ID_W'(hint_pick[IDX_W-1:0]));
                data_reg      <= '0;
            end else if (data_pick[IDX_W]) begin
                out_valid_reg <= 1'b1;
                hdr_reg       <= umsg_hdr(1'b0, UMSG_ID_W'(data_pick[IDX_W-1:0]));
                data_reg      <= slot_data[data_pick[IDX_W-1:0]];
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Pointers move past the slot granted in the matching class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hint_ptr_reg <= '0;
            data_ptr_reg <= '0;
        end else if (load_en) begin
            if (hint_pick[IDX_W])
                hint_ptr_reg <= ptr_after(hint_pick[IDX_W-1:0]);
            else if (data_pick[IDX_W])
                data_ptr_reg <= ptr_after(data_pick[IDX_W-1:0]);
        end
    end

    // Sticky flag for commands addressed beyond the last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if (cmd_fire && id_out_of_range)
            err_reg <= 1'b1;
    end

    assign umsg_out_valid = out_valid_reg;
    assign umsg_out_hdr   = hdr_reg;
    assign umsg_out_data  = data_reg;
    assign umsg_err       = err_reg;

endmodule
